// File: rtl/clock_hm_scan.sv
// clock_hm_scan
//   Hours/minutes BCD timekeeper with a six-digit multiplexed 7-segment
//   display scanner. It counts minutes and hours, driven by the seconds-wrap
//   pulse and by the manual adjust pulses. It then scans hr_t, hr_o, min_t,
//   min_o, sec_t and sec_o onto one shared segment bus.
//
//   Build option: define CLOCK_12H_EN to select 12-hour mode. Hours then run
//   12, 01 .. 11, 12. An internal pm flag toggles on each 11->12 step and is
//   shown on the decimal point of digit 5. Without the macro, hours run 00..23.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   sec_tick  one-cycle pulse at the seconds wrap 59->00
//   sec_t     seconds tens digit (display only)
//   sec_o     seconds ones digit (display only)
//   inc_min   one-cycle manual minute adjust pulse
//   inc_hr    one-cycle manual hour adjust pulse
//   min_t     minute tens digit, BCD, registered
//   min_o     minute ones digit, BCD, registered
//   hr_t      hour tens digit, BCD, registered
//   hr_o      hour ones digit, BCD, registered
//   day_tick  one-cycle pulse when a carry-driven hour step wraps the day
//   sel       active digit index 0..5
//   seg       {dp, g..a} pattern for the active digit; 00 = blank
//
// Parameter
//   SCAN_DIV  clk cycles each digit is held, 2..255
module clock_hm_scan #(
  parameter int SCAN_DIV = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic [3:0] sec_t,
  input  logic [3:0] sec_o,
  input  logic       inc_min,
  input  logic       inc_hr,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] hr_t,
  output logic [3:0] hr_o,
  output logic       day_tick,
  output logic [2:0] sel,
  output logic [7:0] seg
);

  localparam logic [7:0] SCAN_LAST = 8'(SCAN_DIV - 1);

`ifdef CLOCK_12H_EN
  localparam logic [3:0] HR_T_RST = 4'd1;
  localparam logic [3:0] HR_O_RST = 4'd2;
`else
  localparam logic [3:0] HR_T_RST = 4'd0;
  localparam logic [3:0] HR_O_RST = 4'd0;
`endif

  // ---------------------------------------------------------------------
  // Minute / hour counting
  // ---------------------------------------------------------------------
  logic       min_step;
  logic       min_at_max;
  logic       hr_carry;
  logic       hr_step;
  logic [3:0] min_t_nxt, min_o_nxt;
  logic [3:0] hr_t_nxt, hr_o_nxt;
  logic       day_nxt;

`ifdef CLOCK_12H_EN
  logic pm;
  logic pm_nxt;
`endif

  always_comb begin
    // Simultaneous sec_tick and inc_min still step by one.
    min_step   = sec_tick | inc_min;
    min_at_max = (min_t == 4'd5) && (min_o == 4'd9);
    // Only the real seconds wrap carries into the hour; a manual minute
    // wrap leaves the hour alone.
    hr_carry   = sec_tick & min_at_max;
    hr_step    = hr_carry | inc_hr;

    min_t_nxt = min_t;
    min_o_nxt = min_o;
    if (min_step) begin
      if (min_at_max) begin
        min_t_nxt = 4'd0;
        min_o_nxt = 4'd0;
      end else if (min_o == 4'd9) begin
        min_t_nxt = min_t + 4'd1;
        min_o_nxt = 4'd0;
      end else begin
        min_o_nxt = min_o + 4'd1;
      end
    end

    hr_t_nxt = hr_t;
    hr_o_nxt = hr_o;
    day_nxt  = 1'b0;
`ifdef CLOCK_12H_EN
    pm_nxt   = pm;
    if (hr_step) begin
      if (hr_t == 4'd1 && hr_o == 4'd2) begin
        hr_t_nxt = 4'd0;
        hr_o_nxt = 4'd1;
      end else if (hr_t == 4'd0 && hr_o == 4'd9) begin
        hr_t_nxt = 4'd1;
        hr_o_nxt = 4'd0;
      end else if (hr_t == 4'd1 && hr_o == 4'd1) begin
        hr_o_nxt = 4'd2;
        pm_nxt   = ~pm;
        // The day ends when pm falls back to 0 on a carry-driven step.
        day_nxt  = hr_carry & pm;
      end else begin
        hr_o_nxt = hr_o + 4'd1;
      end
    end
`else
    if (hr_step) begin
      if (hr_t == 4'd2 && hr_o == 4'd3) begin
        hr_t_nxt = 4'd0;
        hr_o_nxt = 4'd0;
        day_nxt  = hr_carry;
      end else if (hr_o == 4'd9) begin
        hr_t_nxt = hr_t + 4'd1;
        hr_o_nxt = 4'd0;
      end else begin
        hr_o_nxt = hr_o + 4'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_t    <= 4'd0;
      min_o    <= 4'd0;
      hr_t     <= HR_T_RST;
      hr_o     <= HR_O_RST;
      day_tick <= 1'b0;
    end else begin
      min_t    <= min_t_nxt;
      min_o    <= min_o_nxt;
      hr_t     <= hr_t_nxt;
      hr_o     <= hr_o_nxt;
      day_tick <= day_nxt;
    end
  end

`ifdef CLOCK_12H_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pm <= 1'b0;
    else      pm <= pm_nxt;
  end
`endif

  // ---------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------
  logic [7:0] scan_cnt;
  logic       scan_wrap;
  logic [2:0] sel_nxt;
  logic [3:0] digit_nxt;
  logic [6:0] seg_code;
  logic       dp_nxt;

  always_comb begin
    scan_wrap = (scan_cnt == SCAN_LAST);
    sel_nxt   = (sel == 3'd5) ? 3'd0 : sel + 3'd1;

    // seg is loaded on the same edge as sel, so it decodes the digit
    // that sel is about to point at.
    case (sel_nxt)
      3'd0:    digit_nxt = hr_t;
      3'd1:    digit_nxt = hr_o;
      3'd2:    digit_nxt = min_t;
      3'd3:    digit_nxt = min_o;
      3'd4:    digit_nxt = sec_t;
      default: digit_nxt = sec_o;
    endcase

    case (digit_nxt)
      4'd0:    seg_code = 7'h3F;
      4'd1:    seg_code = 7'h06;
      4'd2:    seg_code = 7'h5B;
      4'd3:    seg_code = 7'h4F;
      4'd4:    seg_code = 7'h66;
      4'd5:    seg_code = 7'h6D;
      4'd6:    seg_code = 7'h7D;
      4'd7:    seg_code = 7'h07;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h6F;
      default: seg_code = 7'h79;  // "E" for non-BCD input
    endcase

    dp_nxt = (sel_nxt == 3'd1) || (sel_nxt == 3'd3);
`ifdef CLOCK_12H_EN
    if (sel_nxt == 3'd5) dp_nxt = pm;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= 8'd0;
      sel      <= 3'd0;
      seg      <= 8'h00;
    end else if (scan_wrap) begin
      scan_cnt <= 8'd0;
      sel      <= sel_nxt;
      seg      <= {dp_nxt, seg_code};
    end else begin
      scan_cnt <= scan_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_clock_hm_scan.sv
// tb_clock_hm_scan
//   Directed and randomized checks of clock_hm_scan (24-hour build).
//   The reference model keeps time as plain integers (minutes 0..59 and
//   hours 0..23). It derives the display position from the number of
//   cycles since reset release.
module tb_clock_hm_scan;
  localparam int DIV = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sec_tick = 1'b0;
  logic       inc_min = 1'b0;
  logic       inc_hr = 1'b0;
  logic [3:0] sec_t = 4'd0;
  logic [3:0] sec_o = 4'd0;
  logic [3:0] min_t, min_o, hr_t, hr_o;
  logic       day_tick;
  logic [2:0] sel;
  logic [7:0] seg;

  always #5 clk = ~clk;

  clock_hm_scan #(.SCAN_DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .sec_tick (sec_tick),
    .sec_t    (sec_t),
    .sec_o    (sec_o),
    .inc_min  (inc_min),
    .inc_hr   (inc_hr),
    .min_t    (min_t),
    .min_o    (min_o),
    .hr_t     (hr_t),
    .hr_o     (hr_o),
    .day_tick (day_tick),
    .sel      (sel),
    .seg      (seg)
  );

  // ---------------- reference model ----------------
  int         tests = 0;
  int         fails = 0;
  int         m_min, m_hr, m_cyc, m_sel;
  logic [7:0] m_seg;
  logic       m_day;
  logic [7:0] exp_scan [6];

  function automatic logic [7:0] dec(int v);
    case (v)
      0: return 8'h3F;
      1: return 8'h06;
      2: return 8'h5B;
      3: return 8'h4F;
      4: return 8'h66;
      5: return 8'h6D;
      6: return 8'h7D;
      7: return 8'h07;
      8: return 8'h7F;
      9: return 8'h6F;
      default: return 8'h79;
    endcase
  endfunction

  function automatic int digit_of(int s);
    case (s)
      0: return m_hr / 10;
      1: return m_hr % 10;
      2: return m_min / 10;
      3: return m_min % 10;
      4: return int'(sec_t);
      default: return int'(sec_o);
    endcase
  endfunction

  task automatic model_reset();
    m_min = 0; m_hr = 0; m_cyc = 0; m_sel = 0; m_seg = 8'h00; m_day = 1'b0;
  endtask

  // One rising edge of the model, evaluated with pre-edge values.
  task automatic model_step();
    bit carry;
    m_cyc++;
    if (m_cyc % DIV == 0) begin
      m_sel = (m_cyc / DIV) % 6;
      m_seg = dec(digit_of(m_sel)) | (((m_sel == 1) || (m_sel == 3)) ? 8'h80 : 8'h00);
    end
    carry = 1'b0;
    m_day = 1'b0;
    if (sec_tick || inc_min) begin
      if (m_min == 59) begin
        m_min = 0;
        carry = sec_tick;
      end else m_min++;
    end
    if (carry || inc_hr) begin
      if (m_hr == 23) begin
        m_hr  = 0;
        m_day = carry;
      end else m_hr++;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic check_all();
    check("min_t", 32'(min_t), 32'(m_min / 10));
    check("min_o", 32'(min_o), 32'(m_min % 10));
    check("hr_t", 32'(hr_t), 32'(m_hr / 10));
    check("hr_o", 32'(hr_o), 32'(m_hr % 10));
    check("day_tick", 32'(day_tick), 32'(m_day));
    check("sel", 32'(sel), 32'(m_sel));
    check("seg", 32'(seg), 32'(m_seg));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(bit st, bit im, bit ih);
    sec_tick = st; inc_min = im; inc_hr = ih;
    @(posedge clk);
    model_step();
    #1;
    sec_tick = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
    check_all();
  endtask

  task automatic set_time(int h, int m);
    while (m_hr != h) cycle(1'b0, 1'b0, 1'b1);
    while (m_min != m) cycle(1'b0, 1'b1, 1'b0);
  endtask

  task automatic minutes_are(string tag, int m);
    check(tag, 32'(min_t) * 10 + 32'(min_o), 32'(m));
  endtask

  task automatic hours_are(string tag, int h);
    check(tag, 32'(hr_t) * 10 + 32'(hr_o), 32'(h));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit found;
    exp_scan[0] = 8'h06; exp_scan[1] = 8'hDB; exp_scan[2] = 8'h4F;
    exp_scan[3] = 8'hE6; exp_scan[4] = 8'h6D; exp_scan[5] = 8'h7D;

    // Reset held: outputs at reset values, edges ignored.
    model_reset();
    #1 check_all();
    sec_tick = 1'b1; inc_min = 1'b1; inc_hr = 1'b1;
    @(posedge clk); #1 check_all();
    @(posedge clk); #1 check_all();
    sec_tick = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
    @(negedge clk) rst = 1'b1;

    // First DIV edges after release: seg stays blank, then sel -> 1.
    for (int i = 0; i < DIV; i++) cycle(1'b0, 1'b0, 1'b0);
    check("first_adv_sel", 32'(sel), 32'd1);

    // 59 -> 00 with sec_tick at 23h: day wrap.
    set_time(23, 59);
    cycle(1'b1, 1'b0, 1'b0);
    minutes_are("wrap_min", 0);
    hours_are("wrap_hr", 0);
    check("wrap_day", 32'(day_tick), 32'd1);
    cycle(1'b0, 1'b0, 1'b0);
    check("wrap_day_1cyc", 32'(day_tick), 32'd0);

    // Manual minute wrap leaves the hour alone.
    set_time(5, 59);
    cycle(1'b0, 1'b1, 1'b0);
    minutes_are("incmin_min", 0);
    hours_are("incmin_hr", 5);
    check("incmin_day", 32'(day_tick), 32'd0);

    // sec_tick and inc_min together: one step.
    set_time(5, 10);
    cycle(1'b1, 1'b1, 1'b0);
    minutes_are("both_min", 11);

    // Carry and inc_hr together: one hour step.
    set_time(5, 59);
    cycle(1'b1, 1'b0, 1'b1);
    hours_are("both_hr", 6);

    // inc_hr-only wrap at 23: no day_tick.
    set_time(23, 0);
    cycle(1'b0, 1'b0, 1'b1);
    hours_are("inchr_wrap", 0);
    check("inchr_day", 32'(day_tick), 32'd0);

    // Scan of 12:34:56.
    set_time(12, 34);
    sec_t = 4'd5; sec_o = 4'd6;
    for (int i = 0; i < 7 * DIV; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (m_cyc % DIV == 0) check("scan_tab", 32'(seg), 32'(exp_scan[m_sel]));
    end

    // Randomized traffic, including non-BCD seconds digits.
    for (int i = 0; i < 1500; i++) begin
      sec_t = 4'($urandom_range(0, 7));
      sec_o = 4'($urandom_range(0, 11));
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    end

    // Reset mid-scan at sel 3, together with a wrapping sec_tick.
    set_time(23, 59);
    found = 1'b0;
    for (int i = 0; i < 10 * DIV && !found; i++) begin
      if (m_sel == 3) found = 1'b1;
      else cycle(1'b0, 1'b0, 1'b0);
    end
    check("reach_sel3", 32'(found), 32'd1);
    sec_tick = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk); #1 check_all();
    @(negedge clk);
    sec_tick = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3 * DIV; i++) cycle(1'b0, 1'b0, 1'b0);
    minutes_are("rst_min", 0);
    check("rst_day", 32'(day_tick), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
